// File: rtl/lfsr_word_gen.sv
// LFSR-based random word generator: Fibonacci or Galois stepping, serialised into
// OUT_W-bit words behind a valid/ready handshake, with zero-safe runtime reseeding.
module lfsr_word_gen #(
  parameter int unsigned      WIDTH = 128,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(128'h0000_0000_8000_0000_0200_2040_0000_0001),
  parameter int unsigned      MODE  = 0,
  parameter int unsigned      OUT_W = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'({WIDTH/2{2'b10}})
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int BCNT_W = $clog2(OUT_W) + 1;

  typedef enum logic {FILL, HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [OUT_W-1:0]   sr_q, sr_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               seed_err_q, seed_err_d;
  logic               step_en;
  logic               word_done;
  logic [OUT_W-1:0]   sr_shift;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
    logic fb;
    fb = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        fb = fb ^ (TAPS[i] & q[WIDTH-1-i]);
      end
      return {q[WIDTH-2:0], fb};
    end
    return {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
  endfunction

  // A reseed pre-empts stepping, so ce is effectively ignored on load cycles.
  assign step_en   = (state_q == FILL) && ce && !seed_load;
  assign word_done = step_en && (bcnt_q == BCNT_W'(OUT_W - 1));
  assign sr_shift  = OUT_W'({sr_q, q_q[WIDTH-1]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (word_done) state_d = HOLD;
        HOLD:    if (out_ready) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    q_d        = q_q;
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    out_data_d = out_data_q;
    seed_err_d = 1'b0;
    if (seed_load) begin
      q_d        = (seed_data != '0) ? seed_data : SEED;
      seed_err_d = (seed_data == '0);
      sr_d       = '0;
      bcnt_d     = '0;
    end else if (step_en) begin
      q_d  = lfsr_step(q_q);
      sr_d = sr_shift;
      if (word_done) begin
        out_data_d = sr_shift;
        bcnt_d     = '0;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= SEED;
      sr_q       <= '0;
      bcnt_q     <= '0;
      out_data_q <= '0;
      seed_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      out_data_q <= out_data_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign seed_err   = seed_err_q;
  assign lfsr_state = q_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Bench for lfsr_word_gen: 8-bit Galois and Fibonacci instances plus the default
// 128-bit Fibonacci, compared against a bit-stream recurrence / polynomial model.
module tb_lfsr_word_gen;

  localparam logic [127:0] TAPS128 = 128'h0000_0000_8000_0000_0200_2040_0000_0001;
  localparam logic [127:0] SEED128 = {64{2'b10}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        ce_g = 0, ld_g = 0, ready_g = 0;
  logic [7:0]  sd_g = '0;
  logic        err_g, valid_g;
  logic [7:0]  data_g, st_g;

  logic        ce_f = 0, ld_f = 0, ready_f = 0;
  logic [7:0]  sd_f = '0;
  logic        err_f, valid_f;
  logic [7:0]  data_f, st_f;

  logic         ce_b = 0, ld_b = 0, ready_b = 0;
  logic [127:0] sd_b = '0;
  logic         err_b, valid_b;
  logic [31:0]  data_b;
  logic [127:0] st_b;

  lfsr_word_gen #(.WIDTH(8), .TAPS(8'h71), .MODE(1), .OUT_W(8)) u_gal (
    .clk(clk), .rst(rst), .ce(ce_g), .seed_load(ld_g), .seed_data(sd_g),
    .seed_err(err_g), .out_valid(valid_g), .out_ready(ready_g),
    .out_data(data_g), .lfsr_state(st_g));

  lfsr_word_gen #(.WIDTH(8), .TAPS(8'h71), .MODE(0), .OUT_W(8)) u_fib (
    .clk(clk), .rst(rst), .ce(ce_f), .seed_load(ld_f), .seed_data(sd_f),
    .seed_err(err_f), .out_valid(valid_f), .out_ready(ready_f),
    .out_data(data_f), .lfsr_state(st_f));

  lfsr_word_gen u_big (
    .clk(clk), .rst(rst), .ce(ce_b), .seed_load(ld_b), .seed_data(sd_b),
    .seed_err(err_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .lfsr_state(st_b));

  logic [127:0] got_g[$];
  logic [127:0] got_b[$];
  logic [127:0] exp_words[$];
  logic [127:0] exp_state;

  // Accepted words are captured mid-cycle, when handshake inputs are stable.
  always @(negedge clk) begin
    if (!rst && valid_g && ready_g && !ld_g) got_g.push_back(128'(data_g));
    if (!rst && valid_b && ready_b && !ld_b) got_b.push_back(128'(data_b));
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output bit stream from the characteristic recurrence (Fibonacci) or from
  // multiplication by x modulo the polynomial (Galois); words group nsteps bits.
  task automatic run_model(input int mode, input int w, input logic [127:0] taps,
                           input logic [127:0] seed, input int ow, input int nsteps);
    bit           bits[$];
    bit           nb;
    logic [127:0] s, mask, word;
    mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
    bits = {};
    if (mode == 0) begin
      for (int k = 0; k < w; k++) bits.push_back(seed[w-1-k]);
      for (int n = 0; bits.size() < nsteps + w; n++) begin
        nb = 1'b0;
        for (int i = 0; i < w; i++) nb = nb ^ (taps[i] & bits[n+i]);
        bits.push_back(nb);
      end
      s = '0;
      for (int k = 0; k < w; k++) s = (s << 1) | 128'(bits[nsteps+k]);
    end else begin
      s = seed;
      for (int n = 0; n < nsteps; n++) begin
        bits.push_back(s[w-1]);
        s = ((s << 1) & mask) ^ (s[w-1] ? taps : 128'd0);
      end
    end
    exp_state = s;
    exp_words = {};
    for (int k = 0; k + ow <= nsteps; k += ow) begin
      word = '0;
      for (int j = 0; j < ow; j++) word = (word << 1) | 128'(bits[k+j]);
      exp_words.push_back(word);
    end
  endtask

  task automatic period_check(input bit galois);
    logic [7:0] st, prev;
    int         steps;
    bit         seen[256];
    bit         saw_zero, repeated, done;
    string      pfx;
    pfx = galois ? "gal" : "fib";
    foreach (seen[i]) seen[i] = 1'b0;
    steps = 0; saw_zero = 0; repeated = 0; done = 0;
    tick;
    if (galois) begin ld_g = 1; sd_g = 8'h01; ce_g = 1; ready_g = 1; end
    else        begin ld_f = 1; sd_f = 8'h01; ce_f = 1; ready_f = 1; end
    tick;
    ld_g = 0; ld_f = 0;
    prev = galois ? st_g : st_f;
    seen[prev] = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      tick;
      st = galois ? st_g : st_f;
      if (st != prev) begin
        steps++;
        if (st == 8'h00) saw_zero = 1'b1;
        else if (st == 8'h01) done = 1'b1;
        else if (seen[st]) repeated = 1'b1;
        seen[st] = 1'b1;
        prev = st;
      end
    end
    checkOutput({pfx, "_period_done"}, 128'(done), 128'd1);
    checkOutput({pfx, "_period_steps"}, 128'(steps), 128'd255);
    checkOutput({pfx, "_period_zero"}, 128'(saw_zero), 128'd0);
    checkOutput({pfx, "_period_repeat"}, 128'(repeated), 128'd0);
  endtask

  initial begin
    logic [7:0]  fib_seq [8];
    logic [7:0]  seed_r, d0, s0;
    int          n, cnt;
    bit          ok;

    fib_seq = '{8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB1, 8'h63};

    repeat (3) tick;
    checkOutput("rst_gal_state", 128'(st_g), 128'hAA);
    checkOutput("rst_gal_valid", 128'(valid_g), 128'd0);
    checkOutput("rst_gal_data", 128'(data_g), 128'd0);
    checkOutput("rst_gal_err", 128'(err_g), 128'd0);
    checkOutput("rst_big_state", st_b, SEED128);
    checkOutput("rst_fib_state", 128'(st_f), 128'hAA);
    rst = 1'b0;

    // Galois: first word, state after it, valid duty cycle, word stream.
    got_g.delete();
    ld_g = 1; sd_g = 8'h01; ce_g = 1; ready_g = 1;
    tick;
    ld_g = 0;
    n = 0;
    while (!valid_g && n < 20) begin tick; n++; end
    checkOutput("gal_first_latency", 128'(n), 128'd8);
    checkOutput("gal_first_word", 128'(data_g), 128'h01);
    checkOutput("gal_state_after_word", 128'(st_g), 128'h71);
    cnt = 0;
    repeat (54) begin tick; if (valid_g) cnt++; end
    checkOutput("gal_valid_duty", 128'(cnt), 128'd6);
    run_model(1, 8, 128'h71, 128'h01, 8, 48);
    checkOutput("gal_word_count", 128'(got_g.size() >= 6), 128'd1);
    for (int i = 0; i < 6 && i < got_g.size(); i++)
      checkOutput($sformatf("gal_word%0d", i), got_g[i], exp_words[i]);

    // Fibonacci: state trajectory from seed 01 and first word.
    ld_f = 1; sd_f = 8'h01; ce_f = 1; ready_f = 1;
    tick;
    ld_f = 0;
    checkOutput("fib_state0", 128'(st_f), 128'h01);
    for (int k = 0; k < 8; k++) begin
      tick;
      checkOutput($sformatf("fib_state%0d", k + 1), 128'(st_f), 128'(fib_seq[k]));
    end
    checkOutput("fib_first_valid", 128'(valid_f), 128'd1);
    checkOutput("fib_first_word", 128'(data_f), 128'h01);

    period_check(1'b1);
    period_check(1'b0);

    // Back-pressure with random ce/out_ready, including a long stall.
    seed_r = 8'($urandom_range(1, 255));
    ld_g = 1; sd_g = seed_r; ce_g = 0; ready_g = 0;
    tick;
    ld_g = 0;
    got_g.delete();
    n = 0;
    while (!valid_g && n < 300) begin ce_g = 1'($urandom_range(0, 1)); tick; n++; end
    checkOutput("bp_first_valid", 128'(valid_g), 128'd1);
    d0 = data_g; s0 = st_g; ok = 1'b1;
    repeat (20) begin
      ce_g = 1'($urandom_range(0, 1));
      tick;
      if (data_g != d0 || st_g != s0 || !valid_g) ok = 1'b0;
    end
    checkOutput("bp_stall_frozen", 128'(ok), 128'd1);
    for (int c = 0; c < 3000 && got_g.size() < 8; c++) begin
      ce_g = 1'($urandom_range(0, 1));
      ready_g = 1'($urandom_range(0, 1));
      tick;
    end
    checkOutput("bp_word_count", 128'(got_g.size() >= 8), 128'd1);
    run_model(1, 8, 128'h71, 128'(seed_r), 8, 64);
    for (int i = 0; i < 8 && i < got_g.size(); i++)
      checkOutput($sformatf("bp_word%0d", i), got_g[i], exp_words[i]);

    // Zero-seed load while holding a word with out_ready high.
    ce_g = 1; ready_g = 0;
    n = 0;
    while (!valid_g && n < 30) begin tick; n++; end
    checkOutput("zs_in_hold", 128'(valid_g), 128'd1);
    ld_g = 1; sd_g = 8'h00; ready_g = 1;
    tick;
    ld_g = 0;
    got_g.delete();
    checkOutput("zs_err_pulse", 128'(err_g), 128'd1);
    checkOutput("zs_valid_dropped", 128'(valid_g), 128'd0);
    checkOutput("zs_state_seed", 128'(st_g), 128'hAA);
    tick;
    checkOutput("zs_err_one_cycle", 128'(err_g), 128'd0);
    n = 0;
    while (got_g.size() < 1 && n < 40) begin tick; n++; end
    run_model(1, 8, 128'h71, 128'hAA, 8, 8);
    checkOutput("zs_got_word", 128'(got_g.size() >= 1), 128'd1);
    if (got_g.size() >= 1) checkOutput("zs_next_word", got_g[0], exp_words[0]);

    // 128-bit Fibonacci: reset mid-word (and Galois instance in HOLD).
    ce_g = 1; ready_g = 0;
    ce_b = 1; ready_b = 1;
    repeat (17) tick;
    ce_b = 0;
    run_model(0, 128, TAPS128, SEED128, 32, 17);
    checkOutput("big_state_17", st_b, exp_state);
    checkOutput("big_valid_midword", 128'(valid_b), 128'd0);
    checkOutput("gal_hold_before_rst", 128'(valid_g), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_gal_valid", 128'(valid_g), 128'd0);
    checkOutput("rst_async_big_state", st_b, SEED128);
    ok = 1'b1;
    repeat (3) begin
      tick;
      if (valid_b || valid_g || st_b != SEED128) ok = 1'b0;
    end
    checkOutput("rst_held_quiet", 128'(ok), 128'd1);
    rst = 1'b0;
    got_b.delete();
    ce_b = 1; ready_b = 1;
    n = 0;
    while (!valid_b && n < 100) begin tick; n++; end
    checkOutput("big_first_latency", 128'(n), 128'd32);
    for (int c = 0; c < 300 && got_b.size() < 4; c++) tick;
    checkOutput("big_word_count", 128'(got_b.size() >= 4), 128'd1);
    run_model(0, 128, TAPS128, SEED128, 32, 128);
    for (int i = 0; i < 4 && i < got_b.size(); i++)
      checkOutput($sformatf("big_word%0d", i), got_b[i], exp_words[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
